// File: rtl/cpl_tag_tracker_if.sv
// rtl/cpl_tag_tracker_if.sv - request/completion/tag-return bundle for the completion tag tracker
interface cpl_tag_tracker_if;
  logic        i_ExtTag;
  logic        i_ReqValid;
  logic [7:0]  i8_ReqTag;
  logic [12:0] i13_ReqBytes;
  logic        i_CplValid;
  logic [7:0]  i8_CplTag;
  logic [12:0] i13_CplBytes;
  logic [2:0]  i3_CplStatus;
  logic        o_TagPush;
  logic [7:0]  o8_TagReturned;
  logic        o_CplLast;
  logic        o_CplErr;
  logic [8:0]  o9_Outstanding;
  logic        o_Idle;

  modport master (
    output i_ExtTag, i_ReqValid, i8_ReqTag, i13_ReqBytes,
    output i_CplValid, i8_CplTag, i13_CplBytes, i3_CplStatus,
    input  o_TagPush, o8_TagReturned, o_CplLast, o_CplErr, o9_Outstanding, o_Idle
  );

  modport slave (
    input  i_ExtTag, i_ReqValid, i8_ReqTag, i13_ReqBytes,
    input  i_CplValid, i8_CplTag, i13_CplBytes, i3_CplStatus,
    output o_TagPush, o8_TagReturned, o_CplLast, o_CplErr, o9_Outstanding, o_Idle
  );
endinterface

// File: rtl/cpl_tag_tracker.sv
// rtl/cpl_tag_tracker.sv - per-tag outstanding read tracker closing tags on final, errored or overrun completions
module cpl_tag_tracker #(
  parameter int pTAGS = 256
) (
  input logic               i_Clk,
  input logic               i_ARstN,
  cpl_tag_tracker_if.slave  bus
);

  logic              arm_q;
  logic              ext_q;
  logic              flush_q, flush_d;
  logic [pTAGS-1:0]  valid_q, valid_d;
  logic [12:0]       rem_q [pTAGS];
  logic [12:0]       rem_d [pTAGS];
  logic [8:0]        count_q, count_d;
  logic              push_q, push_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              idle_q, idle_d;
  logic [7:0]        tag_ret_q, tag_ret_d;

  logic              cpl_fire, req_fire, cpl_hit, cpl_close, req_ok, cpl_sc;
  logic [12:0]       cpl_rem;

  function automatic logic tag_legal(input logic [7:0] tag, input logic ext);
    return (int'(tag) < pTAGS) && (ext || (tag < 8'd32));
  endfunction

  // arm_q gates all traffic so the first accepted request lands on the second edge after release
  assign cpl_fire  = arm_q && bus.i_CplValid;
  assign req_fire  = arm_q && bus.i_ReqValid;
  assign cpl_sc    = (bus.i3_CplStatus == 3'b000);
  assign cpl_hit   = cpl_fire && !flush_q && tag_legal(bus.i8_CplTag, bus.i_ExtTag)
                     && valid_q[bus.i8_CplTag];
  assign cpl_rem   = rem_q[bus.i8_CplTag];
  assign cpl_close = cpl_hit && (!cpl_sc || (bus.i13_CplBytes >= cpl_rem));
  // judged on pre-edge state: a tag still open (even if closing now) drops the request
  assign req_ok    = req_fire && !flush_q && tag_legal(bus.i8_ReqTag, bus.i_ExtTag)
                     && !valid_q[bus.i8_ReqTag];

  always_comb begin
    valid_d   = valid_q;
    rem_d     = rem_q;
    count_d   = count_q;
    flush_d   = arm_q && (bus.i_ExtTag != ext_q);
    push_d    = cpl_close;
    last_d    = cpl_hit && cpl_sc && (bus.i13_CplBytes == cpl_rem);
    err_d     = cpl_fire && (!cpl_hit || !cpl_sc || (bus.i13_CplBytes > cpl_rem));
    tag_ret_d = cpl_close ? bus.i8_CplTag : 8'h00;

    if (cpl_close) begin
      valid_d[bus.i8_CplTag] = 1'b0;
    end else if (cpl_hit) begin
      rem_d[bus.i8_CplTag] = cpl_rem - bus.i13_CplBytes;
    end

    if (req_ok) begin
      valid_d[bus.i8_ReqTag] = 1'b1;
      rem_d[bus.i8_ReqTag]   = bus.i13_ReqBytes;
    end

    count_d = count_q + {8'd0, req_ok} - {8'd0, cpl_close};

    // tag-space change invalidates everything silently; the pool is rebuilt upstream
    if (flush_q) begin
      valid_d = '0;
      count_d = 9'd0;
    end

    idle_d = (count_d == 9'd0);
  end

  always_ff @(posedge i_Clk or negedge i_ARstN) begin
    if (!i_ARstN) begin
      arm_q     <= 1'b0;
      ext_q     <= 1'b0;
      flush_q   <= 1'b0;
      valid_q   <= '0;
      count_q   <= 9'd0;
      push_q    <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
      idle_q    <= 1'b1;
      tag_ret_q <= 8'h00;
    end else begin
      arm_q     <= 1'b1;
      ext_q     <= bus.i_ExtTag;
      flush_q   <= flush_d;
      valid_q   <= valid_d;
      count_q   <= count_d;
      push_q    <= push_d;
      last_q    <= last_d;
      err_q     <= err_d;
      idle_q    <= idle_d;
      tag_ret_q <= tag_ret_d;
    end
  end

  // remaining counts are only read behind a valid bit, so they carry no reset
  always_ff @(posedge i_Clk) begin
    rem_q <= rem_d;
  end

  assign bus.o_TagPush      = push_q;
  assign bus.o8_TagReturned = tag_ret_q;
  assign bus.o_CplLast      = last_q;
  assign bus.o_CplErr       = err_q;
  assign bus.o9_Outstanding = count_q;
  assign bus.o_Idle         = idle_q;

endmodule

// File: doc/cpl_tag_tracker.md
CPL_TAG_TRACKER -- requirements
Module: cpl_tag_tracker

Interface
REQ-001 Parameter pTAGS, default 256, table depth; tags at or above pTAGS are always unexpected.
REQ-002 i_Clk  in  1  sole clock; all logic on rising edge.
REQ-003 i_ARstN  in  1  asynchronous active-low reset.
REQ-004 i_ExtTag  in  1  1 = tags 0..255 legal, 0 = tags 0..31 legal.
REQ-005 i_ReqValid  in  1  MemRd issued this cycle.
REQ-006 i8_ReqTag  in  8  tag of issued MemRd.
REQ-007 i13_ReqBytes  in  13  requested byte count, 1..4096.
REQ-008 i_CplValid  in  1  completion header accepted this cycle.
REQ-009 i8_CplTag  in  8  completion tag.
REQ-010 i13_CplBytes  in  13  valid payload bytes in this completion, 0..4096.
REQ-011 i3_CplStatus  in  3  completion status; 000 = SC.
REQ-012 o_TagPush  out  1  one-cycle pulse returning a tag to the tag pool.
REQ-013 o8_TagReturned  out  8  tag being returned, valid with o_TagPush.
REQ-014 o_CplLast  out  1  pulse: completion closed its request normally.
REQ-015 o_CplErr  out  1  pulse: unexpected tag, overrun, or non-SC status.
REQ-016 o9_Outstanding  out  9  count of open tags, 0..256.
REQ-017 o_Idle  out  1  high when o9_Outstanding = 0.

Function
REQ-018 Table per tag: valid bit plus 13-bit remaining-byte count, register based, combinational read.
REQ-019 Request: i_ReqValid sets valid[i8_ReqTag], remaining = i13_ReqBytes, at the same edge.
REQ-020 Request to an already-valid tag or a tag illegal under i_ExtTag is ignored; no table or count change.
REQ-021 Completion lookup uses table state before the current edge; table update at that edge.
REQ-022 Unexpected: tag invalid or illegal under i_ExtTag -> o_CplErr only, no push, table unchanged.
REQ-023 Non-SC status on valid tag -> clear valid, o_TagPush, o_CplErr; o_CplLast low.
REQ-024 SC, i13_CplBytes < remaining -> remaining -= i13_CplBytes; no pulses.
REQ-025 SC, i13_CplBytes = remaining -> clear valid, o_TagPush, o_CplLast.
REQ-026 SC, i13_CplBytes > remaining (overrun) -> clear valid, o_TagPush, o_CplErr.
REQ-027 All outputs registered; pulses appear exactly one cycle after i_CplValid; one completion per cycle at full rate.
REQ-028 Back-to-back completions on the same tag see the first one's update on the second cycle.
REQ-029 Same-cycle request and completion on the same tag: completion judged on prior state; request applied only if prior entry invalid; if completion closes the entry the request is dropped.
REQ-030 o9_Outstanding: +1 on accepted request, -1 on valid-tag close, unchanged when both occur in the same cycle; never wraps.
REQ-031 i_ExtTag change (registered edge detect): all valid bits and o9_Outstanding cleared next cycle; no o_TagPush for flushed tags; completions in that cycle treated as unexpected.

Reset
REQ-032 While i_ARstN = 0: all valid bits 0, o9_Outstanding = 0, o_Idle = 1, o_TagPush/o_CplLast/o_CplErr = 0, o8_TagReturned = 0.
REQ-033 Reset assertion mid-split-completion discards all state; deassertion is synchronised internally and the first request is accepted on the second edge after release.

Verification
REQ-034 ExtTag=1; req tag 0x05, 256 B; cpl 64 B x4 SC -> pulses only on 4th cpl: o_TagPush, o8_TagReturned=0x05, o_CplLast; o9_Outstanding 1 -> 0.
REQ-035 ExtTag=0; req tag 0x40 -> ignored, outstanding 0; cpl tag 0x40 -> o_CplErr, no push.
REQ-036 req tag 0x10, 128 B; cpl status 001 -> o_TagPush tag 0x10, o_CplErr, o_CplLast low; later cpl tag 0x10 -> o_CplErr only.
REQ-037 req tag 0x20, 100 B; cpl 128 B -> o_TagPush, o_CplErr, o9_Outstanding decrements.
REQ-038 Open tags 0..31, toggle i_ExtTag 0->1 -> outstanding 0 next-plus-one cycle, no pushes; 32 new requests accepted.
REQ-039 Same cycle req tag 0x03 and closing cpl on open tag 0x07 -> push 0x07, outstanding unchanged; reset asserted mid-stream -> all outputs to REQ-032 values immediately.
